// File: rtl/atomrvcore_decode_stage.sv
// RV32I decode stage: register file with optional writeback bypass, instruction
// decode into a registered execute bundle, valid/ready handshake, flush and load-use stall.
module atomrvcore_decode_stage #(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REGISTERS      = 32,
  parameter int unsigned ALUOP_WIDTH    = 6,
  parameter bit          BYPASS_EN      = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DATAWIDTH-1:0]      instr_i,
  input  logic [DATAWIDTH-1:0]      pc_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      flush_i,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATAWIDTH-1:0]      wb_data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATAWIDTH-1:0]      pc_o,
  output logic [DATAWIDTH-1:0]      operand_a_o,
  output logic [DATAWIDTH-1:0]      operand_b_o,
  output logic [DATAWIDTH-1:0]      rs2_data_o,
  output logic [DATAWIDTH-1:0]      immed_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [ALUOP_WIDTH-1:0]    aluop_o,
  output logic                      rwr_en_o,
  output logic                      dr_en_o,
  output logic                      dwr_en_o,
  output logic                      branch_o,
  output logic                      jal_o,
  output logic                      jalr_o,
  output logic                      lui_o,
  output logic                      auipc_o,
  output logic                      illegal_o
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_NONE = 5'd0,  ALU_ADD  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_SUB  = 5'd10, ALU_BEQ  = 5'd11,
    ALU_BNE  = 5'd12, ALU_BLT  = 5'd13, ALU_BGE  = 5'd14, ALU_BLTU = 5'd15,
    ALU_BGEU = 5'd16, ALU_JAL  = 5'd17
  } aluop_e;

  function automatic aluop_e alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [DATAWIDTH-1:0]      r_regs [REGISTERS];
  logic [6:0]                w_opcode;
  logic [2:0]                w_funct3;
  logic [6:0]                w_funct7;
  logic [REG_ADDR_WIDTH-1:0] w_rs1, w_rs2, w_rd_field;
  logic [DATAWIDTH-1:0]      w_rs1_data, w_rs2_data;
  logic signed [31:0]        w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic [DATAWIDTH-1:0]      w_imm, w_op_a, w_op_b;
  logic [REG_ADDR_WIDTH-1:0] w_rd;
  aluop_e                    w_aluop;
  logic w_rwr, w_dr, w_dwr, w_br, w_jal, w_jalr, w_lui, w_auipc, w_ill;
  logic w_use_rs1, w_use_rs2, w_b_is_rs2;
  logic w_hazard, w_adv, w_ready, w_accept;

  logic                      r_valid;
  logic [DATAWIDTH-1:0]      r_pc, r_op_a, r_op_b, r_rs2_data, r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [ALUOP_WIDTH-1:0]    r_aluop;
  logic r_rwr, r_dr, r_dwr, r_br, r_jal, r_jalr, r_lui, r_auipc, r_ill;

  assign w_opcode   = instr_i[6:0];
  assign w_rd_field = instr_i[11:7];
  assign w_funct3   = instr_i[14:12];
  assign w_rs1      = instr_i[19:15];
  assign w_rs2      = instr_i[24:20];
  assign w_funct7   = instr_i[31:25];

  assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_u = {instr_i[31:12], 12'b0};
  assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // x0 is hardwired; a same-cycle writeback wins over the stored value when bypass is enabled.
  assign w_rs1_data = (w_rs1 == '0) ? '0 :
                      (BYPASS_EN && wb_en_i && (wb_rd_i == w_rs1)) ? wb_data_i : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == '0) ? '0 :
                      (BYPASS_EN && wb_en_i && (wb_rd_i == w_rs2)) ? wb_data_i : r_regs[w_rs2];

  always_comb begin
    w_imm32    = '0;
    w_aluop    = ALU_NONE;
    w_rd       = w_rd_field;
    w_rwr      = 1'b0;
    w_dr       = 1'b0;
    w_dwr      = 1'b0;
    w_br       = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_lui      = 1'b0;
    w_auipc    = 1'b0;
    w_ill      = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_b_is_rs2 = 1'b0;
    w_op_a     = w_rs1_data;
    case (w_opcode)
      OP_R: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_b_is_rs2 = 1'b1;
        w_rwr      = 1'b1;
        if (w_funct7 == 7'h00)                          w_aluop = alu_arith(w_funct3, 1'b0);
        else if (w_funct7 == 7'h20 && w_funct3 == 3'd0) w_aluop = ALU_SUB;
        else if (w_funct7 == 7'h20 && w_funct3 == 3'd5) w_aluop = ALU_SRA;
        else                                            w_ill   = 1'b1;
      end
      OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_imm32   = w_imm_i;
        w_rwr     = 1'b1;
        w_aluop   = alu_arith(w_funct3, w_funct7[5]);
        if ((w_funct3 == 3'd1 && w_funct7 != 7'h00) ||
            (w_funct3 == 3'd5 && w_funct7 != 7'h00 && w_funct7 != 7'h20))
          w_ill = 1'b1;
      end
      OP_LOAD: begin
        w_use_rs1 = 1'b1;
        w_imm32   = w_imm_i;
        w_rwr     = 1'b1;
        w_dr      = 1'b1;
      end
      OP_JALR: begin
        w_use_rs1 = 1'b1;
        w_imm32   = w_imm_i;
        w_rwr     = 1'b1;
        w_jalr    = 1'b1;
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_imm32   = w_imm_s;
        w_rd      = '0;
        w_dwr     = 1'b1;
      end
      OP_BRANCH: begin
        w_use_rs1  = 1'b1;
        w_use_rs2  = 1'b1;
        w_b_is_rs2 = 1'b1;
        w_imm32    = w_imm_b;
        w_rd       = '0;
        w_br       = 1'b1;
        case (w_funct3)
          3'd0:    w_aluop = ALU_BEQ;
          3'd1:    w_aluop = ALU_BNE;
          3'd4:    w_aluop = ALU_BLT;
          3'd5:    w_aluop = ALU_BGE;
          3'd6:    w_aluop = ALU_BLTU;
          3'd7:    w_aluop = ALU_BGEU;
          default: w_ill   = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_imm32 = w_imm_u;
        w_op_a  = '0;
        w_rwr   = 1'b1;
        w_lui   = 1'b1;
      end
      OP_AUIPC: begin
        w_imm32 = w_imm_u;
        w_op_a  = pc_i;
        w_rwr   = 1'b1;
        w_auipc = 1'b1;
      end
      OP_JAL: begin
        w_imm32 = w_imm_j;
        w_rwr   = 1'b1;
        w_jal   = 1'b1;
        w_aluop = ALU_JAL;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal encodings keep operand routing but must not cause any side effect downstream.
    if (w_ill) begin
      w_aluop = ALU_NONE;
      w_rwr   = 1'b0;
      w_dr    = 1'b0;
      w_dwr   = 1'b0;
      w_br    = 1'b0;
      w_jal   = 1'b0;
      w_jalr  = 1'b0;
    end
    if (w_rd == '0) w_rwr = 1'b0;
  end

  assign w_imm  = DATAWIDTH'(w_imm32);
  assign w_op_b = w_b_is_rs2 ? w_rs2_data : w_imm;

  assign w_hazard = r_valid && r_dr && (r_rd != '0) &&
                    ((w_use_rs1 && (w_rs1 == r_rd)) || (w_use_rs2 && (w_rs2 == r_rd)));
  assign w_adv    = !r_valid || ready_i;
  assign w_ready  = rst_ni && w_adv && !w_hazard && !flush_i;
  assign w_accept = valid_i && w_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REGISTERS; i++) r_regs[i[REG_ADDR_WIDTH-1:0]] <= '0;
    end else if (wb_en_i && (wb_rd_i != '0)) begin
      r_regs[wb_rd_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_aluop    <= '0;
      r_rwr      <= 1'b0;
      r_dr       <= 1'b0;
      r_dwr      <= 1'b0;
      r_br       <= 1'b0;
      r_jal      <= 1'b0;
      r_jalr     <= 1'b0;
      r_lui      <= 1'b0;
      r_auipc    <= 1'b0;
      r_ill      <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pc       <= pc_i;
        r_op_a     <= w_op_a;
        r_op_b     <= w_op_b;
        r_rs2_data <= w_rs2_data;
        r_imm      <= w_imm;
        r_rd       <= w_rd;
        r_aluop    <= ALUOP_WIDTH'(w_aluop);
        r_rwr      <= w_rwr;
        r_dr       <= w_dr;
        r_dwr      <= w_dwr;
        r_br       <= w_br;
        r_jal      <= w_jal;
        r_jalr     <= w_jalr;
        r_lui      <= w_lui;
        r_auipc    <= w_auipc;
        r_ill      <= w_ill;
      end
    end
  end

  assign ready_o     = w_ready;
  assign valid_o     = r_valid;
  assign pc_o        = r_pc;
  assign operand_a_o = r_op_a;
  assign operand_b_o = r_op_b;
  assign rs2_data_o  = r_rs2_data;
  assign immed_o     = r_imm;
  assign rd_o        = r_rd;
  assign aluop_o     = r_aluop;
  assign rwr_en_o    = r_rwr;
  assign dr_en_o     = r_dr;
  assign dwr_en_o    = r_dwr;
  assign branch_o    = r_br;
  assign jal_o       = r_jal;
  assign jalr_o      = r_jalr;
  assign lui_o       = r_lui;
  assign auipc_o     = r_auipc;
  assign illegal_o   = r_ill;

endmodule

// File: tb/tb_atomrvcore_decode_stage.sv
// Bench for atomrvcore_decode_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the decode stage.
module tb_atomrvcore_decode_stage;

  typedef struct packed {
    logic [31:0] pc, a, b, rs2d, imm;
    logic [4:0]  rd;
    logic [5:0]  aluop;
    logic rwr, dr, dwr, br, jal, jalr, lui, auipc, ill;
  } bnd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0, pc = '0, wb_data = '0;
  logic        valid_in = 1'b0, ready_in = 1'b1, flush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;

  logic        ready_o, valid_o;
  logic [31:0] pc_o, operand_a_o, operand_b_o, rs2_data_o, immed_o;
  logic [4:0]  rd_o;
  logic [5:0]  aluop_o;
  logic rwr_en_o, dr_en_o, dwr_en_o, branch_o, jal_o, jalr_o, lui_o, auipc_o, illegal_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bnd_t        m_b;
  logic        m_valid;
  bnd_t        dut_b;

  always #5 clk = ~clk;

  atomrvcore_decode_stage #(
    .DATAWIDTH(32), .REG_ADDR_WIDTH(5), .REGISTERS(32), .ALUOP_WIDTH(6), .BYPASS_EN(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .pc_i(pc),
    .valid_i(valid_in), .ready_o(ready_o), .flush_i(flush),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .valid_o(valid_o), .ready_i(ready_in),
    .pc_o(pc_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .rs2_data_o(rs2_data_o), .immed_o(immed_o), .rd_o(rd_o), .aluop_o(aluop_o),
    .rwr_en_o(rwr_en_o), .dr_en_o(dr_en_o), .dwr_en_o(dwr_en_o), .branch_o(branch_o),
    .jal_o(jal_o), .jalr_o(jalr_o), .lui_o(lui_o), .auipc_o(auipc_o), .illegal_o(illegal_o)
  );

  assign dut_b = {pc_o, operand_a_o, operand_b_o, rs2_data_o, immed_o, rd_o, aluop_o,
                  rwr_en_o, dr_en_o, dwr_en_o, branch_o, jal_o, jalr_o, lui_o, auipc_o, illegal_o};

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic bit ref_ready();
    bit hz;
    hz = m_valid && m_b.dr && (m_b.rd != 5'd0) &&
         ((reads_rs1(instr[6:0]) && instr[19:15] == m_b.rd) ||
          (reads_rs2(instr[6:0]) && instr[24:20] == m_b.rd));
    return rst_n && (!m_valid || ready_in) && !hz && !flush;
  endfunction

  function automatic bnd_t ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    bnd_t o;
    int lut_alu [8];
    int lut_br  [8];
    int code;
    bit ill;
    logic [31:0] sx, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0] f3;
    logic [6:0] f7, op;
    lut_alu = '{1, 2, 3, 4, 5, 6, 8, 9};
    lut_br  = '{11, 12, 0, 0, 13, 14, 15, 16};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    sx    = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    imm_i = (sx << 12) | 32'(ins[31:20]);
    imm_s = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    imm_b = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFF_F000;
    imm_j = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    o = '0; code = 0; ill = 0;
    o.pc = ipc; o.a = r1; o.rs2d = r2; o.rd = ins[11:7];
    case (op)
      7'h33: begin
        o.rwr = 1;
        if (f7 == 7'h00) code = lut_alu[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 10;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
        else ill = 1;
      end
      7'h13: begin
        o.imm = imm_i; o.rwr = 1; code = lut_alu[f3];
        if (f3 == 3'd5 && f7 == 7'h20) code = 7;
        if ((f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && f7 != 0 && f7 != 7'h20)) ill = 1;
      end
      7'h03: begin o.imm = imm_i; o.dr = 1; o.rwr = 1; end
      7'h67: begin o.imm = imm_i; o.jalr = 1; o.rwr = 1; end
      7'h23: begin o.imm = imm_s; o.dwr = 1; o.rd = 0; end
      7'h63: begin
        o.imm = imm_b; o.br = 1; o.rd = 0; code = lut_br[f3];
        if (code == 0) ill = 1;
      end
      7'h37: begin o.imm = imm_u; o.a = 0; o.lui = 1; o.rwr = 1; end
      7'h17: begin o.imm = imm_u; o.a = ipc; o.auipc = 1; o.rwr = 1; end
      7'h6F: begin o.imm = imm_j; o.jal = 1; o.rwr = 1; code = 17; end
      default: ill = 1;
    endcase
    o.b = (op == 7'h33 || op == 7'h63) ? r2 : o.imm;
    if (ill) begin
      code = 0; o.rwr = 0; o.dr = 0; o.dwr = 0; o.br = 0; o.jal = 0; o.jalr = 0;
    end
    if (o.rd == 5'd0) o.rwr = 0;
    o.ill = ill;
    o.aluop = 6'(code);
    return o;
  endfunction

  // Advance one clock, evolving the model from the inputs held across the edge.
  task automatic tick();
    bnd_t nb;
    logic nv;
    nb = m_b; nv = m_valid;
    if (!rst_n) begin
      nb = '0; nv = 1'b0;
    end else if (flush) begin
      nv = 1'b0;
    end else if (!m_valid || ready_in) begin
      if (valid_in && ref_ready()) begin
        nb = ref_decode(instr, pc, ref_read(instr[19:15]), ref_read(instr[24:20]));
        nv = 1'b1;
      end else begin
        nv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      m_regs[wb_rd] = wb_data;
    end
    m_b = nb; m_valid = nv;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; valid_in = 0; flush = 0; wb_en = 0; ready_in = 1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    tick(); tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (dut_b !== '0) begin bad++; $display("FAIL reset_bundle got=%h exp=0", dut_b); end
    rst_n = 1; instr = 32'h0020_81B3; pc = 32'h0000_0010; valid_in = 1;
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", ready_o); end
    tick(); valid_in = 0;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", valid_o); end
    total++; if (operand_a_o !== 32'h0 || operand_b_o !== 32'h0)
      begin bad++; $display("FAIL add_operands got=%h/%h exp=0/0", operand_a_o, operand_b_o); end
    total++; if (aluop_o !== 6'd1 || rd_o !== 5'd3 || rwr_en_o !== 1'b1)
      begin bad++; $display("FAIL add_ctrl got=%0d/%0d/%b exp=1/3/1", aluop_o, rd_o, rwr_en_o); end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_rd = 5'd1; wb_data = 32'h0000_1234;
    instr = 32'hFFF0_8293; pc = 32'h20; valid_in = 1;
    tick(); valid_in = 0; wb_en = 0;
    total++; if (operand_a_o !== 32'h1234 || operand_b_o !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL bypass_ops got=%h/%h exp=00001234/ffffffff", operand_a_o, operand_b_o); end
    total++; if (aluop_o !== 6'd1 || rd_o !== 5'd5)
      begin bad++; $display("FAIL bypass_ctrl got=%0d/%0d exp=1/5", aluop_o, rd_o); end
    tick();
  endtask

  task automatic test_immediates();
    instr = 32'hFE00_0EE3; pc = 32'h40; valid_in = 1;
    tick();
    total++; if (immed_o !== 32'hFFFF_FFFC || branch_o !== 1'b1 || aluop_o !== 6'd11 || rd_o !== 5'd0)
      begin bad++; $display("FAIL beq_imm got=%h/%b/%0d/%0d exp=fffffffc/1/11/0", immed_o, branch_o, aluop_o, rd_o); end
    instr = 32'h0010_00EF; pc = 32'h44;
    tick(); valid_in = 0;
    total++; if (immed_o !== 32'h0000_0800 || jal_o !== 1'b1 || aluop_o !== 6'd17 || rwr_en_o !== 1'b1)
      begin bad++; $display("FAIL jal_imm got=%h/%b/%0d/%b exp=00000800/1/17/1", immed_o, jal_o, aluop_o, rwr_en_o); end
    tick();
  endtask

  task automatic test_load_use();
    ready_in = 1; instr = 32'h0001_2303; pc = 32'h200; valid_in = 1;
    tick();
    total++; if (valid_o !== 1'b1 || dr_en_o !== 1'b1 || rd_o !== 5'd6)
      begin bad++; $display("FAIL lw_issue got=%b/%b/%0d exp=1/1/6", valid_o, dr_en_o, rd_o); end
    instr = 32'h0063_03B3; pc = 32'h204;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL hazard_stall got=%b exp=0", ready_o); end
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL hazard_bubble got=%b exp=0", valid_o); end
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL hazard_release got=%b exp=1", ready_o); end
    tick(); valid_in = 0;
    total++; if (valid_o !== 1'b1 || pc_o !== 32'h204 || rd_o !== 5'd7)
      begin bad++; $display("FAIL add_after_stall got=%b/%h/%0d exp=1/00000204/7", valid_o, pc_o, rd_o); end
    tick();
  endtask

  task automatic test_back_to_back_flush();
    ready_in = 1; instr = 32'h0020_81B3; pc = 32'h100; valid_in = 1;
    tick();
    ready_in = 0; instr = 32'hFFF0_8293; pc = 32'h104;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, ready_o); end
      tick();
      total++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || rd_o !== 5'd3 || aluop_o !== 6'd1)
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d/%0d exp=1/00000100/3/1", k, valid_o, pc_o, rd_o, aluop_o); end
    end
    flush = 1;
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    flush = 0; ready_in = 1; valid_in = 0;
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b exp=0", valid_o); end
  endtask

  task automatic test_illegal_x0();
    instr = 32'h0000_007F; pc = 32'h300; valid_in = 1;
    tick();
    total++; if (illegal_o !== 1'b1 || rwr_en_o !== 1'b0 || aluop_o !== 6'd0)
      begin bad++; $display("FAIL illegal got=%b/%b/%0d exp=1/0/0", illegal_o, rwr_en_o, aluop_o); end
    instr = 32'h0050_0013; pc = 32'h304; wb_en = 1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    tick();
    total++; if (rwr_en_o !== 1'b0 || operand_a_o !== 32'h0 || operand_b_o !== 32'h5 || illegal_o !== 1'b0)
      begin bad++; $display("FAIL addi_x0 got=%b/%h/%h exp=0/00000000/00000005", rwr_en_o, operand_a_o, operand_b_o); end
    wb_en = 0; instr = 32'h0000_0433; pc = 32'h308;
    tick(); valid_in = 0;
    total++; if (operand_a_o !== 32'h0 || operand_b_o !== 32'h0 || rd_o !== 5'd8)
      begin bad++; $display("FAIL x0_reads_zero got=%h/%h/%0d exp=0/0/8", operand_a_o, operand_b_o, rd_o); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    for (int n = 0; n < 800; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    ins[31:25] = 7'h00;
        2:       ins[31:25] = 7'h20;
        default: ins[31:25] = 7'($urandom);
      endcase
      instr    = ins;
      pc       = $urandom & 32'hFFFF_FFFC;
      rst_n    = ($urandom_range(0, 59) != 0);
      valid_in = ($urandom_range(0, 9) < 7);
      ready_in = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      wb_en    = $urandom_range(0, 1) == 1;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      #1;
      total++; if (ready_o !== ref_ready())
        begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, ready_o, ref_ready()); end
      tick();
      total++; if ({valid_o, dut_b} !== {m_valid, m_b})
        begin bad++; $display("FAIL rnd_bundle[%0d] got=%b_%h exp=%b_%h", n, valid_o, dut_b, m_valid, m_b); end
    end
    rst_n = 1; valid_in = 0; flush = 0; wb_en = 0; ready_in = 1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_b = '0; m_valid = 1'b0;
    test_reset();
    test_bypass();
    test_immediates();
    test_load_use();
    test_back_to_back_flush();
    test_illegal_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
